// File: rtl/rr_arb_16_pkg.sv
// Shared definitions for the 16-way round-robin arbiter.
package rr_arb_16_pkg;

  localparam int N_REQ = 16;
  localparam int IDX_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arb_16_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_arb_16_if;
  import rr_arb_16_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_vld;
  logic             expire;

  modport master (
    output req,
    input  gnt,
    input  gnt_idx,
    input  gnt_vld,
    input  expire
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_idx,
    output gnt_vld,
    output expire
  );
endinterface

// File: rtl/rr_arb_16_onehot_dec.sv
// 4-to-16 one-hot decoder with enable; output is all zeros when disabled.
module onehot_dec_4_16
  import rr_arb_16_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [N_REQ-1:0] oh
);

  // One comparator per output bit keeps the result one-hot by construction.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_bit
      assign oh[gi] = en && (idx == IDX_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/rr_arb_16.sv
// Round-robin arbiter for 16 requesters with a bounded hold time per grant.
// The grant is fully registered: there is no combinational path from req to gnt.
module rr_arb_16
  import rr_arb_16_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 8
) (
  input  logic         clk,
  input  logic         rst,
  rr_arb_16_if.slave   bus
);

  state_t            state_reg, state_next;
  logic [IDX_W-1:0]  gnt_idx_reg, gnt_idx_next;
  logic [IDX_W-1:0]  ptr_reg, ptr_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic              expire_reg, expire_next;

  logic [N_REQ-1:0]  search_req;
  logic [IDX_W-1:0]  search_base;
  logic [IDX_W-1:0]  winner;
  logic              found;
  logic [IDX_W-1:0]  idx_inc;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  // Rotate so that 'base' sits at bit 0, take the lowest set bit, then undo
  // the rotation by adding base back (4-bit wrap gives modulo 16).
  function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                             input logic [IDX_W-1:0] base);
    logic [N_REQ-1:0] rot;
    logic [IDX_W-1:0] off;
    logic             hit;
    rot = (r >> base) | (r << (5'(N_REQ) - {1'b0, base}));
    off = '0;
    hit = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = IDX_W'(i);
        hit = 1'b1;
      end
    end
    return {hit, off + base};
  endfunction

  assign idx_inc = gnt_idx_reg + 4'd1;

  // Single shared search: from ptr while idle, from holder+1 while granting;
  // a voluntarily released holder is masked out of its own re-arbitration.
  always_comb begin
    search_base = ptr_reg;
    search_req  = bus.req;
    if (state_reg == GRANT) begin
      search_base = idx_inc;
      if (!bus.req[gnt_idx_reg]) begin
        search_req = bus.req & ~(16'd1 << gnt_idx_reg);
      end
    end
    {found, winner} = rr_pick(search_req, search_base);
  end

  // Next-state logic: grant, voluntary release, hold timeout, or continue holding.
  always_comb begin
    state_next    = state_reg;
    gnt_idx_next  = gnt_idx_reg;
    ptr_next      = ptr_reg;
    hold_cnt_next = hold_cnt_reg;
    expire_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (found) begin
          state_next    = GRANT;
          gnt_idx_next  = winner;
          hold_cnt_next = '0;
        end
      end
      GRANT: begin
        if (!bus.req[gnt_idx_reg]) begin
          ptr_next      = idx_inc;
          hold_cnt_next = '0;
          if (found) begin
            gnt_idx_next = winner;
          end else begin
            state_next = IDLE;
          end
        end else if (hold_cnt_reg == HOLD_LAST) begin
          // Holder still requests, so the search always finds someone,
          // possibly the holder itself at lowest priority.
          expire_next   = 1'b1;
          ptr_next      = idx_inc;
          gnt_idx_next  = winner;
          hold_cnt_next = '0;
        end else begin
          hold_cnt_next = hold_cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and grant registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      gnt_idx_reg  <= '0;
      ptr_reg      <= '0;
      hold_cnt_reg <= '0;
      expire_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      gnt_idx_reg  <= gnt_idx_next;
      ptr_reg      <= ptr_next;
      hold_cnt_reg <= hold_cnt_next;
      expire_reg   <= expire_next;
    end
  end

  assign bus.gnt_idx = gnt_idx_reg;
  assign bus.gnt_vld = (state_reg == GRANT);
  assign bus.expire  = expire_reg;

  onehot_dec_4_16 u_dec (
    .idx (gnt_idx_reg),
    .en  (state_reg == GRANT),
    .oh  (bus.gnt)
  );

endmodule
